// File: rtl/mnk_game_fsm_if.sv
// Move-offer channel between the input front end (master) and the game controller (slave).
// A move transfers on a rising clk edge where move_valid && move_ready; the master holds
// move_x/move_y/move_player stable while move_valid is high and the transfer has not yet happened.
interface mnk_game_fsm_if #(
  parameter int CW = 2
);
  logic          move_valid;
  logic          move_ready;
  logic [CW-1:0] move_x;
  logic [CW-1:0] move_y;
  logic [1:0]    move_player;

  modport master (output move_valid, move_x, move_y, move_player, input move_ready);
  modport slave  (input move_valid, move_x, move_y, move_player, output move_ready);
endinterface

// File: rtl/mnk_game_fsm.sv
// Two-player N x N, K-in-a-row game controller: validates moves, then spends a fixed
// four cycles checking the lines through the last move before taking the next one.
module mnk_game_fsm #(
  parameter int N  = 3,
  parameter int K  = 3,
  parameter int CW = $clog2(N),
  parameter int MW = $clog2(N*N+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  mnk_game_fsm_if.slave    mv,
  output logic             move_accept,
  output logic             move_reject,
  output logic [1:0]       reject_code,
  output logic [1:0]       turn,
  output logic [MW-1:0]    move_count,
  output logic [1:0]       winner,
  output logic             game_over,
  output logic             busy,
  output logic [1:0]       state_dbg,
  output logic [2*N*N-1:0] board_flat
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT_MOVE, S_CHECK, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    board [N][N];
  logic [CW-1:0] last_x, last_y;
  logic          last_p;
  logic [1:0]    dir;
  logic          win_flag;
  logic          handshake, out_of_range, bad_player, occupied;
  logic [1:0]    code_d;
  logic          line_win, win_any, full;
  int            fwd, back, dx, dy, xf, yf, xb, yb;

  assign mv.move_ready = (state_q == S_WAIT_MOVE);
  assign busy          = (state_q == S_CHECK);
  assign state_dbg     = state_q;
  assign handshake     = mv.move_valid && (state_q == S_WAIT_MOVE);
  assign full          = (move_count == MW'(N*N));
  assign win_any       = win_flag || line_win;

  for (genvar gy = 0; gy < N; gy++) begin : g_row
    for (genvar gx = 0; gx < N; gx++) begin : g_col
      assign board_flat[2*(gy*N+gx) +: 2] = board[gy][gx];
    end
  end

  // Rejection reasons in priority order; the cell is only looked at once coordinates are legal.
  always_comb begin
    out_of_range = (int'(mv.move_x) >= N) || (int'(mv.move_y) >= N);
    bad_player   = (mv.move_player > 2'd1) || ((turn != 2'd3) && (mv.move_player != turn));
    occupied     = !out_of_range && (board[mv.move_y][mv.move_x] != 2'b11);
    code_d       = 2'd0;
    if (out_of_range)    code_d = 2'd2;
    else if (bad_player) code_d = 2'd3;
    else if (occupied)   code_d = 2'd1;
  end

  // Run length through the last move along direction dir; a run only extends while unbroken.
  always_comb begin
    dx = 1; dy = 0;
    unique case (dir)
      2'd0: begin dx = 1; dy = 0;  end
      2'd1: begin dx = 0; dy = 1;  end
      2'd2: begin dx = 1; dy = 1;  end
      default: begin dx = 1; dy = -1; end
    endcase
    fwd = 0; back = 0; xf = 0; yf = 0; xb = 0; yb = 0;
    for (int i = 1; i < K; i++) begin
      xf = int'(last_x) + i*dx;
      yf = int'(last_y) + i*dy;
      xb = int'(last_x) - i*dx;
      yb = int'(last_y) - i*dy;
      if (fwd == i-1 && xf >= 0 && xf < N && yf >= 0 && yf < N)
        if (board[yf[CW-1:0]][xf[CW-1:0]] == {1'b0, last_p}) fwd = i;
      if (back == i-1 && xb >= 0 && xb < N && yb >= 0 && yb < N)
        if (board[yb[CW-1:0]][xb[CW-1:0]] == {1'b0, last_p}) back = i;
    end
    line_win = (1 + fwd + back >= K);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (start) state_d = S_WAIT_MOVE;
      S_WAIT_MOVE: if (handshake && code_d == 2'd0) state_d = S_CHECK;
      S_CHECK:     if (dir == 2'd3) state_d = (win_any || full) ? S_DONE : S_WAIT_MOVE;
      S_DONE:      if (start) state_d = S_WAIT_MOVE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      board       <= '{default: '{default: 2'b11}};
      last_x      <= '0;
      last_y      <= '0;
      last_p      <= 1'b0;
      dir         <= 2'd0;
      win_flag    <= 1'b0;
      turn        <= 2'd3;
      move_count  <= '0;
      winner      <= 2'd3;
      game_over   <= 1'b0;
      move_accept <= 1'b0;
      move_reject <= 1'b0;
      reject_code <= 2'd0;
    end else begin
      state_q     <= state_d;
      move_accept <= 1'b0;
      move_reject <= 1'b0;
      unique case (state_q)
        S_WAIT_MOVE: if (handshake) begin
          if (code_d != 2'd0) begin
            move_reject <= 1'b1;
            reject_code <= code_d;
          end else begin
            board[mv.move_y][mv.move_x] <= mv.move_player;
            last_x      <= mv.move_x;
            last_y      <= mv.move_y;
            last_p      <= mv.move_player[0];
            turn        <= {1'b0, ~mv.move_player[0]};
            move_count  <= move_count + MW'(1);
            dir         <= 2'd0;
            win_flag    <= 1'b0;
            move_accept <= 1'b1;
          end
        end
        S_CHECK: begin
          dir <= dir + 2'd1;
          if (line_win) win_flag <= 1'b1;
          if (dir == 2'd3) begin
            if (win_any) begin
              winner    <= {1'b0, last_p};
              game_over <= 1'b1;
            end else if (full) begin
              winner    <= 2'd3;
              game_over <= 1'b1;
            end
          end
        end
        S_DONE: if (start) begin
          board      <= '{default: '{default: 2'b11}};
          turn       <= 2'd3;
          move_count <= '0;
          winner     <= 2'd3;
          game_over  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mnk_game_fsm.sv
// Directed bench for mnk_game_fsm: a 3x3/K=3 instance (sel 0) and a 7x7/K=4 instance (sel 1).
module tb_mnk_game_fsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;

  always #5 clk = ~clk;

  mnk_game_fsm_if #(.CW(2)) ifa ();
  mnk_game_fsm_if #(.CW(3)) ifb ();

  logic       acc_a, rej_a, over_a, busy_a, acc_b, rej_b, over_b, busy_b;
  logic [1:0] code_a, turn_a, win_a, st_a, code_b, turn_b, win_b, st_b;
  logic [3:0] cnt_a;
  logic [5:0] cnt_b;
  logic [17:0] flat_a;
  logic [97:0] flat_b;

  mnk_game_fsm #(.N(3), .K(3)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .mv(ifa),
    .move_accept(acc_a), .move_reject(rej_a), .reject_code(code_a), .turn(turn_a),
    .move_count(cnt_a), .winner(win_a), .game_over(over_a), .busy(busy_a),
    .state_dbg(st_a), .board_flat(flat_a));

  mnk_game_fsm #(.N(7), .K(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mv(ifb),
    .move_accept(acc_b), .move_reject(rej_b), .reject_code(code_b), .turn(turn_b),
    .move_count(cnt_b), .winner(win_b), .game_over(over_b), .busy(busy_b),
    .state_dbg(st_b), .board_flat(flat_b));

  logic         rdy [2], acc [2], rej [2], ovr [2], bsy [2];
  logic [1:0]   code [2], trn [2], win [2], st [2];
  logic [7:0]   cnt [2];
  logic [127:0] brd [2];
  assign rdy[0] = ifa.move_ready; assign rdy[1] = ifb.move_ready;
  assign acc[0] = acc_a;  assign acc[1] = acc_b;
  assign rej[0] = rej_a;  assign rej[1] = rej_b;
  assign ovr[0] = over_a; assign ovr[1] = over_b;
  assign bsy[0] = busy_a; assign bsy[1] = busy_b;
  assign code[0] = code_a; assign code[1] = code_b;
  assign trn[0] = turn_a; assign trn[1] = turn_b;
  assign win[0] = win_a;  assign win[1] = win_b;
  assign st[0] = st_a;    assign st[1] = st_b;
  assign cnt[0] = {4'b0, cnt_a};
  assign cnt[1] = {2'b0, cnt_b};
  assign brd[0] = {110'b0, flat_a};
  assign brd[1] = {30'b0, flat_b};

  int           n_cmp = 0, n_fail = 0;
  int           nsz [2] = '{3, 7};
  logic [127:0] exp_brd [2];
  int           exp_cnt [2];
  logic [1:0]   exp_turn [2], exp_code [2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] empty_board(input int sel);
    return (128'(1) << (2*nsz[sel]*nsz[sel])) - 128'(1);
  endfunction

  task automatic model_new_game(input int sel);
    exp_brd[sel]  = empty_board(sel);
    exp_cnt[sel]  = 0;
    exp_turn[sel] = 2'd3;
  endtask

  task automatic drive(input int sel, input logic v, input int x, input int y, input int p);
    if (sel == 0) begin
      ifa.move_valid = v; ifa.move_x = x[1:0]; ifa.move_y = y[1:0]; ifa.move_player = p[1:0];
    end else begin
      ifb.move_valid = v; ifb.move_x = x[2:0]; ifb.move_y = y[2:0]; ifb.move_player = p[1:0];
    end
  endtask

  task automatic start_game(input int sel);
    string tg;
    tg = $sformatf("start%0d", sel);
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    model_new_game(sel);
    chk({tg, " ready"}, rdy[sel], 1);
    chk({tg, " over"},  ovr[sel], 0);
    chk({tg, " winner"}, win[sel], 3);
    chk({tg, " count"}, cnt[sel], 0);
    chk({tg, " turn"},  trn[sel], 3);
    chk({tg, " board"}, brd[sel], exp_brd[sel]);
  endtask

  // exp_c = 0 means the move must be accepted; otherwise the expected reject code.
  task automatic do_move(input int sel, input int x, input int y, input int p,
                         input int exp_c, input logic exp_over, input logic [1:0] exp_win);
    string tg;
    int guard;
    tg = $sformatf("m%0d(%0d,%0d)p%0d", sel, x, y, p);
    drive(sel, 1'b1, x, y, p);
    guard = 0;
    while (!rdy[sel] && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({tg, " ready_in"}, rdy[sel], 1);
    @(posedge clk); #1;
    drive(sel, 1'b0, 0, 0, 0);
    if (exp_c == 0) begin
      exp_brd[sel][2*(y*nsz[sel]+x) +: 2] = p[1:0];
      exp_cnt[sel]++;
      exp_turn[sel] = (p == 0) ? 2'd1 : 2'd0;
      chk({tg, " accept"}, acc[sel], 1);
      chk({tg, " reject"}, rej[sel], 0);
      chk({tg, " busy"},   bsy[sel], 1);
      chk({tg, " ready1"}, rdy[sel], 0);
      chk({tg, " board"},  brd[sel], exp_brd[sel]);
      chk({tg, " count"},  cnt[sel], exp_cnt[sel]);
      chk({tg, " turn"},   trn[sel], exp_turn[sel]);
      chk({tg, " code"},   code[sel], exp_code[sel]);
      repeat (4) @(posedge clk);
      #1;
      chk({tg, " over"},   ovr[sel], exp_over);
      chk({tg, " winner"}, win[sel], exp_win);
      chk({tg, " ready5"}, rdy[sel], !exp_over);
      chk({tg, " busy5"},  bsy[sel], 0);
    end else begin
      exp_code[sel] = exp_c[1:0];
      chk({tg, " reject"}, rej[sel], 1);
      chk({tg, " accept"}, acc[sel], 0);
      chk({tg, " code"},   code[sel], exp_code[sel]);
      chk({tg, " ready1"}, rdy[sel], 1);
      chk({tg, " board"},  brd[sel], exp_brd[sel]);
      chk({tg, " count"},  cnt[sel], exp_cnt[sel]);
    end
  endtask

  initial begin
    drive(0, 1'b0, 0, 0, 0);
    drive(1, 1'b0, 0, 0, 0);
    exp_code[0] = 2'd0; exp_code[1] = 2'd0;
    model_new_game(0);
    model_new_game(1);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst state", st[0], 0);
    chk("rst ready", rdy[0], 0);
    chk("rst busy",  bsy[0], 0);
    chk("rst acc",   acc[0], 0);
    chk("rst rej",   rej[0], 0);
    chk("rst code",  code[0], 0);
    chk("rst turn",  trn[0], 3);
    chk("rst count", cnt[0], 0);
    chk("rst winner", win[0], 3);
    chk("rst over",  ovr[0], 0);
    chk("rst board", brd[0], exp_brd[0]);
    chk("rst board7", brd[1], exp_brd[1]);
    reset = 1'b0;

    // Game 1 on 3x3: rejections, then P0 wins along row 0
    start_game(0);
    do_move(0, 3, 0, 0, 2, 0, 3);
    do_move(0, 3, 1, 2, 2, 0, 3);
    do_move(0, 0, 0, 0, 0, 0, 3);
    do_move(0, 1, 0, 0, 3, 0, 3);
    do_move(0, 1, 0, 2, 3, 0, 3);
    do_move(0, 0, 0, 1, 1, 0, 3);
    do_move(0, 0, 1, 1, 0, 0, 3);
    do_move(0, 1, 0, 0, 0, 0, 3);
    do_move(0, 1, 1, 1, 0, 0, 3);
    do_move(0, 2, 0, 0, 0, 1, 0);

    // Moves offered after game over are neither accepted nor rejected
    drive(0, 1'b1, 2, 2, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("done acc", acc[0], 0);
      chk("done rej", rej[0], 0);
      chk("done count", cnt[0], 5);
    end
    drive(0, 1'b0, 0, 0, 0);

    // Game 2: draw
    start_game(0);
    do_move(0, 0, 0, 0, 0, 0, 3);
    do_move(0, 1, 0, 1, 0, 0, 3);
    do_move(0, 2, 0, 0, 0, 0, 3);
    do_move(0, 1, 1, 1, 0, 0, 3);
    do_move(0, 0, 1, 0, 0, 0, 3);
    do_move(0, 2, 1, 1, 0, 0, 3);
    do_move(0, 1, 2, 0, 0, 0, 3);
    do_move(0, 0, 2, 1, 0, 0, 3);
    do_move(0, 2, 2, 0, 0, 1, 3);
    chk("draw count", cnt[0], 9);

    // Game 3: P1 wins down column 0
    start_game(0);
    do_move(0, 0, 0, 1, 0, 0, 3);
    do_move(0, 1, 0, 0, 0, 0, 3);
    do_move(0, 0, 1, 1, 0, 0, 3);
    do_move(0, 1, 1, 0, 0, 0, 3);
    do_move(0, 0, 2, 1, 0, 1, 1);

    // 7x7, K=4: P0 3-long on row 5 plus a move at the start of row 6, P1 anti-diagonal
    start_game(1);
    do_move(1, 4, 5, 0, 0, 0, 3);
    do_move(1, 6, 0, 1, 0, 0, 3);
    do_move(1, 5, 5, 0, 0, 0, 3);
    do_move(1, 5, 1, 1, 0, 0, 3);
    do_move(1, 6, 5, 0, 0, 0, 3);
    do_move(1, 4, 2, 1, 0, 0, 3);
    do_move(1, 0, 6, 0, 0, 0, 3);
    do_move(1, 3, 3, 1, 0, 1, 1);

    // Reset during the second cycle of the win check
    start_game(0);
    drive(0, 1'b1, 1, 1, 0);
    @(posedge clk); #1;
    drive(0, 1'b0, 0, 0, 0);
    chk("mid busy", bsy[0], 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_new_game(0);
    chk("mid state", st[0], 0);
    chk("mid ready", rdy[0], 0);
    chk("mid busy0", bsy[0], 0);
    chk("mid acc",   acc[0], 0);
    chk("mid rej",   rej[0], 0);
    chk("mid code",  code[0], 0);
    chk("mid turn",  trn[0], 3);
    chk("mid count", cnt[0], 0);
    chk("mid winner", win[0], 3);
    chk("mid over",  ovr[0], 0);
    chk("mid board", brd[0], exp_brd[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mnk_game_fsm.md
# mnk_game_fsm

Parametrised two-player m,n,k board-game controller (N×N board, K-in-a-row wins), generalising the fixed 3×3 tic-tac-toe FSM. Accepts moves over a valid/ready handshake and validates them with coded rejection reasons. After each accepted move it runs a fixed-latency, multi-cycle win check along the four lines through the last move. It sits between the move-input front end and the display/score logic, and supports back-to-back games without reset.

## Interface
Parameters:
- N, default 3: board dimension; legal range 3..15.
- K, default 3: win length; legal range 3..N.
- CW, default $clog2(N): coordinate width (derived, not overridden).
- MW, default $clog2(N*N+1): move counter width (derived).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  begin/restart a game; honoured in S_IDLE and S_DONE.
- move_valid  in  1  move offered.
- move_ready  out  1  high only in S_WAIT_MOVE.
- move_x  in  CW  column.
- move_y  in  CW  row.
- move_player  in  2  0 or 1; other values are illegal.
- move_accept  out  1  one-cycle pulse, move written.
- move_reject  out  1  one-cycle pulse, move refused.
- reject_code  out  2  reason, valid with move_reject: 1 occupied, 2 out of range, 3 wrong/illegal player; holds last value otherwise.
- turn  out  2  player expected next; 3 = either (first move).
- move_count  out  MW  accepted moves this game.
- winner  out  2  0/1 winner, 3 = none/draw.
- game_over  out  1  game finished.
- busy  out  1  high in S_CHECK.

## Operation
- Cell encoding: 2'b11 empty, 0/1 = owner. The board is a register array of N×N 2-bit cells.
- Reset: all cells 3, state S_IDLE, turn 3, winner 3, move_count 0, game_over 0, move_accept 0, move_reject 0, reject_code 0, move_ready 0, busy 0.
- S_IDLE: on start, go to S_WAIT_MOVE.
- S_WAIT_MOVE: a handshake is move_valid & move_ready. The move is checked in priority order:
  - code 2 if x≥N or y≥N;
  - else code 3 if player>1, or if turn≠3 and player≠turn;
  - else code 1 if the cell is occupied.
- A rejected move leaves the board unchanged and the state stays S_WAIT_MOVE.
- An accepted move:
  - writes the cell, latches last_x/last_y/last_p;
  - sets turn = 1−player and increments move_count;
  - goes to S_CHECK with direction index d=0.
- S_CHECK: takes one cycle per direction d = 0 horizontal, 1 vertical, 2 diagonal, 3 anti-diagonal.
  - Count contiguous last_p cells from (last_x,last_y) forward and backward, up to K−1 each side, with bounds checked at 0 and N−1.
  - If 1+fwd+back ≥ K, set the sticky win flag.
  - Always run all 4 directions; there is no early exit.
- End of the d=3 cycle:
  - win → winner=last_p, game_over=1, go to S_DONE;
  - else move_count==N*N → winner=3, game_over=1, go to S_DONE;
  - else go to S_WAIT_MOVE.
- S_DONE: moves are not accepted. On start, clear the board, set turn=3, move_count=0, winner=3, game_over=0, then go to S_WAIT_MOVE.
- start in S_WAIT_MOVE or S_CHECK is ignored.
- reset asserted in any state, including mid-S_CHECK, restores reset values on the next edge.

## Timing
- Handshake at edge T (sampled in S_WAIT_MOVE).
- At T+1:
  - the cell is visible;
  - move_accept or move_reject pulses for one cycle;
  - accepted: busy=1, move_ready=0;
  - rejected: move_ready stays 1, so a new move is takeable at T+1.
- S_CHECK occupies T+1..T+4.
- At T+5, one of:
  - game_over/winner are updated;
  - move_ready=1 again.
- Fixed check latency is 4 cycles, so the move-to-move throughput is 5 cycles.
- start → S_WAIT_MOVE with move_ready=1 on the next cycle.
- Restart from S_DONE: the board is all-empty one cycle after start.

## Test plan
- N=3,K=3: P0 (0,0),(1,0),(2,0) interleaved with P1 (0,1),(1,1) → after the 5th accept, winner=0, game_over=1 at T+5, move_ready=0.
- N=3: fill the board without a line (P0 (0,0),(2,0),(1,1)... standard draw order) → move_count=9, winner=3, game_over=1.
- Rejections: x=3 on N=3 → code 2; P0 twice in a row → code 3; player=2 → code 3; replay an occupied cell → code 1; board and move_count unchanged.
- N=7,K=4: anti-diagonal (6,0),(5,1),(4,2),(3,3) by P1 → winner=1; also a 3-long line plus an edge-wrap attempt at x=6→0 → no win.
- Reset asserted on the 2nd cycle of S_CHECK → next cycle all outputs at reset values and the board is empty.
- After game_over, assert start → board empty, turn=3, move_count=0, and a new game is playable to a P1 win.
